// File: rtl/gate_delay_pipe.sv
// rtl/gate_delay_pipe.sv - cycle-level transport-delay model of D=(A&B)|~C, E=~C with hazard counting
module gate_delay_pipe #(
    parameter int WIDTH   = 4,
    parameter int AND_LAT = 3,
    parameter int NOT_LAT = 1,
    parameter int OR_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic             out_valid,
    output logic             hazard,
    output logic [7:0]       glitch_cnt
);

    // Latency of the slowest path; the ideal reference and valid flag travel this far.
    localparam int L = ((AND_LAT > NOT_LAT) ? AND_LAT : NOT_LAT) + OR_LAT;

    if (AND_LAT < 1 || AND_LAT > 16) begin : g_bad_and_lat
        $error("gate_delay_pipe: AND_LAT must be within 1..16");
    end
    if (NOT_LAT < 1 || NOT_LAT > 16) begin : g_bad_not_lat
        $error("gate_delay_pipe: NOT_LAT must be within 1..16");
    end
    if (OR_LAT < 1 || OR_LAT > 16) begin : g_bad_or_lat
        $error("gate_delay_pipe: OR_LAT must be within 1..16");
    end

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] nc;
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] or_in;
    logic [WIDTH-1:0] ideal_in;
    logic [WIDTH-1:0] d_ideal;

    assign ab       = A & B;
    assign nc       = ~C;
    assign or_in    = w1 | E;
    assign ideal_in = ab | nc;

    // Each gate owns its own delay line, so skew between paths shows up as glitches on D.
    gate_delay_pipe_shift #(.W(WIDTH), .N(AND_LAT)) u_and_pipe (
        .clk (clk), .rst (rst), .d (ab), .q (w1)
    );

    gate_delay_pipe_shift #(.W(WIDTH), .N(NOT_LAT)) u_not_pipe (
        .clk (clk), .rst (rst), .d (nc), .q (E)
    );

    gate_delay_pipe_shift #(.W(WIDTH), .N(OR_LAT)) u_or_pipe (
        .clk (clk), .rst (rst), .d (or_in), .q (D)
    );

    // Glitch-free reference: the whole function evaluated at input time and delayed L cycles.
    gate_delay_pipe_shift #(.W(WIDTH), .N(L)) u_ideal_pipe (
        .clk (clk), .rst (rst), .d (ideal_in), .q (d_ideal)
    );

    gate_delay_pipe_shift #(.W(1), .N(L)) u_valid_pipe (
        .clk (clk), .rst (rst), .d (in_valid), .q (out_valid)
    );

    // Startup fill of D is masked because out_valid stays low until the reference has arrived.
    assign hazard = out_valid && (D != d_ideal);

    // Saturating hazard counter; a clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (cnt_clr) begin
            glitch_cnt <= 8'd0;
        end else if (hazard && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

endmodule

// Fixed-length shift register of W-bit words, N stages, cleared asynchronously.
module gate_delay_pipe_shift #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N*W-1:0] sr;

    if (N == 1) begin : g_one
        // Single stage: plain register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr <= '0;
            end else begin
                sr <= d;
            end
        end
    end else begin : g_many
        // Oldest word sits in the top slice; new word enters at the bottom.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr <= '0;
            end else begin
                sr <= {sr[(N-1)*W-1:0], d};
            end
        end
    end

    assign q = sr[N*W-1 -: W];

endmodule

// File: tb/tb_gate_delay_pipe.sv
// tb/tb_gate_delay_pipe.sv - randomized and directed bench for gate_delay_pipe against a history-based model
module tb_gate_delay_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0, b = '0, c = '0;
    logic       in_valid = 1'b0;
    logic       cnt_clr = 1'b0;

    logic [3:0] d0, e0, d1, e1;
    logic       ov0, hz0, ov1, hz1;
    logic [7:0] gc0, gc1;

    always #5 clk = ~clk;

    gate_delay_pipe u_dut (
        .clk (clk), .rst (rst), .A (a), .B (b), .C (c),
        .in_valid (in_valid), .cnt_clr (cnt_clr),
        .D (d0), .E (e0), .out_valid (ov0), .hazard (hz0), .glitch_cnt (gc0)
    );

    gate_delay_pipe #(.WIDTH(4), .AND_LAT(2), .NOT_LAT(2), .OR_LAT(2)) u_eq (
        .clk (clk), .rst (rst), .A (a), .B (b), .C (c),
        .in_valid (in_valid), .cnt_clr (cnt_clr),
        .D (d1), .E (e1), .out_valid (ov1), .hazard (hz1), .glitch_cnt (gc1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-edge history of sampled inputs since reset (edge k at index k-1).
    logic [3:0] h_ab[$];
    logic [3:0] h_nc[$];
    logic       h_v[$];
    int         edge_n = 0;
    int         cnt_m[2];
    logic       hz_m[2];
    int         la[2] = '{3, 2};
    int         ln[2] = '{1, 2};
    int         lo[2] = '{2, 2};

    function automatic logic [3:0] s_ab(int k);
        if (k < 1 || k > h_ab.size()) return 4'h0;
        return h_ab[k-1];
    endfunction

    function automatic logic [3:0] s_nc(int k);
        if (k < 1 || k > h_nc.size()) return 4'h0;
        return h_nc[k-1];
    endfunction

    function automatic logic s_v(int k);
        if (k < 1 || k > h_v.size()) return 1'b0;
        return h_v[k-1];
    endfunction

    // Outputs visible after edge n: each path shows the input sampled (latency-1) edges earlier.
    function automatic void model(input int j, input int n, output logic [3:0] md,
                                  output logic [3:0] me, output logic mv, output logic mh);
        int lmax;
        logic [3:0] mid;
        lmax = ((la[j] > ln[j]) ? la[j] : ln[j]) + lo[j];
        md   = s_ab(n - la[j] - lo[j] + 1) | s_nc(n - ln[j] - lo[j] + 1);
        me   = s_nc(n - ln[j] + 1);
        mid  = s_ab(n - lmax + 1) | s_nc(n - lmax + 1);
        mv   = s_v(n - lmax + 1);
        mh   = mv && (md != mid);
    endfunction

    task automatic model_clear();
        h_ab.delete();
        h_nc.delete();
        h_v.delete();
        edge_n = 0;
        for (int j = 0; j < 2; j++) begin
            cnt_m[j] = 0;
            hz_m[j]  = 1'b0;
        end
    endtask

    task automatic verify(input int j);
        logic [3:0] md, me;
        logic mv, mh;
        model(j, edge_n, md, me, mv, mh);
        if (j == 0) begin
            chk($sformatf("D[%0d]@%0d", j, edge_n), d0, md);
            chk($sformatf("E[%0d]@%0d", j, edge_n), e0, me);
            chk($sformatf("out_valid[%0d]@%0d", j, edge_n), ov0, mv);
            chk($sformatf("hazard[%0d]@%0d", j, edge_n), hz0, mh);
            chk($sformatf("glitch_cnt[%0d]@%0d", j, edge_n), gc0, cnt_m[j]);
        end else begin
            chk($sformatf("D[%0d]@%0d", j, edge_n), d1, md);
            chk($sformatf("E[%0d]@%0d", j, edge_n), e1, me);
            chk($sformatf("out_valid[%0d]@%0d", j, edge_n), ov1, mv);
            chk($sformatf("hazard[%0d]@%0d", j, edge_n), hz1, mh);
            chk($sformatf("glitch_cnt[%0d]@%0d", j, edge_n), gc1, cnt_m[j]);
        end
    endtask

    // One clock: drive, advance model at the edge, check 1 time unit later, return at negedge.
    task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] ci,
                        input logic vi, input logic clri);
        logic [3:0] md, me;
        logic mv, mh;
        a = ai; b = bi; c = ci; in_valid = vi; cnt_clr = clri;
        @(posedge clk);
        edge_n++;
        h_ab.push_back(ai & bi);
        h_nc.push_back(~ci);
        h_v.push_back(vi);
        for (int j = 0; j < 2; j++) begin
            if (clri) cnt_m[j] = 0;
            else if (hz_m[j] && cnt_m[j] < 255) cnt_m[j] = cnt_m[j] + 1;
            model(j, edge_n, md, me, mv, mh);
            hz_m[j] = mh;
        end
        #1;
        verify(0);
        verify(1);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_D"}, d0, 4'h0);
        chk({tag, "_E"}, e0, 4'h0);
        chk({tag, "_ov"}, ov0, 1'b0);
        chk({tag, "_hz"}, hz0, 1'b0);
        chk({tag, "_gc"}, gc0, 8'd0);
        chk({tag, "_gc_eq"}, gc1, 8'd0);
    endtask

    // Power-on fill from reset with constant zero operands.
    task automatic run_033(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
            if (k == 1) chk({tag, "_E_edge1"}, e0, 4'hF);
            if (k == 2) chk({tag, "_D_edge2"}, d0, 4'h0);
            if (k == 3) chk({tag, "_D_edge3"}, d0, 4'hF);
            if (k == 4) chk({tag, "_ov_edge4"}, ov0, 1'b0);
            if (k == 5) chk({tag, "_ov_edge5"}, ov0, 1'b1);
            if (k == 8) chk({tag, "_gc"}, gc0, 8'd0);
        end
    endtask

    // Zeros, then all-ones: the fast NOT path drops D before the slow AND path raises it.
    task automatic rep_035(input logic clr_on_hazard);
        for (int k = 0; k < 6; k++) step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(4'hF, 4'hF, 4'hF, 1'b1, clr_on_hazard && hz_m[0]);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_033("r033");

        // Rising AND path with C held high: D follows ideal, no hazard.
        for (int k = 0; k < 6; k++) step(4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
            if (k == 4) chk("r034_D_before", d0, 4'h0);
            if (k == 5) chk("r034_D_after", d0, 4'hF);
        end

        step(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        rep_035(1'b0);
        chk("r035_gc", gc0, 8'd2);
        chk("r038_gc_eq", gc1, 8'd0);

        for (int r = 0; r < 130; r++) rep_035(1'b0);
        chk("r036_sat", gc0, 8'd255);

        rep_035(1'b1);
        chk("r036_clr", gc0, 8'd0);

        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset pulse entirely between two rising edges.
        for (int k = 0; k < 4; k++) step(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        model_clear();
        check_zero("async_rst");
        #1 rst = 1'b0;
        run_033("r037");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
